// File: rtl/core_run_sequencer_pkg.sv
// Shared definitions for the run sequencer that drives the single-cycle RV32I core.
//   state_t      : sequencer FSM states (3-bit encoding, exposed for debug)
//   halt_cause_t : reason the sequencer entered HALT
//   RV32_*       : instruction words the sequencer must recognise or emit
package core_run_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE   = 3'd0,
    CAUSE_EXT    = 3'd1,
    CAUSE_EBREAK = 3'd2,
    CAUSE_ECALL  = 3'd3,
    CAUSE_LIMIT  = 3'd4
  } halt_cause_t;

  localparam logic [31:0] RV32_NOP    = 32'h0000_0013;
  localparam logic [31:0] RV32_ECALL  = 32'h0000_0073;
  localparam logic [31:0] RV32_EBREAK = 32'h0010_0073;

endpackage

// File: rtl/core_run_sequencer_if.sv
// Instruction-memory read bus between the sequencer (master) and a synchronous
// instruction memory (slave).
//   imem_rd_en : read strobe from the master
//   imem_addr  : byte address of the word to read
//   imem_rdata : read data from the slave
// Handshake: fixed-latency read with no back-pressure. The master holds
// imem_rd_en high for one cycle with imem_addr valid in that cycle; the slave
// must present the addressed word on imem_rdata exactly one cycle later. There
// is no ready signal -- the slave is always able to accept a read.
interface core_run_sequencer_if #(
  parameter int XLEN = 32
);
  logic            imem_rd_en;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_rd_en, output imem_addr, input imem_rdata);
  modport slave  (input imem_rd_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/core_run_sequencer_sys_instr_detect.sv
// Combinational classifier for the two system opcodes that stop the sequencer.
//   instr_word : fetched instruction word
//   is_ecall   : word is exactly ECALL
//   is_ebreak  : word is exactly EBREAK
module core_run_sequencer_sys_instr_detect
  import core_run_sequencer_pkg::*;
(
  input  logic [31:0] instr_word,
  output logic        is_ecall,
  output logic        is_ebreak
);

  // Full-word matches: any other SYSTEM encoding (CSR ops etc.) is executed.
  assign is_ecall  = (instr_word == RV32_ECALL);
  assign is_ebreak = (instr_word == RV32_EBREAK);

endmodule

// File: rtl/core_run_sequencer.sv
// Run sequencer for the single-cycle RV32I core. Fetches each instruction at the
// core's PC from a synchronous instruction memory, presents it on `instruction`
// and pulses `en` for one cycle per instruction (FETCH -> DECODE -> EXEC).
//   clk, rst       : clock, synchronous active-low reset
//   run_req        : start free-running execution (sampled in IDLE)
//   step_req       : execute one instruction (sampled in IDLE)
//   halt_req       : external stop request
//   clr_req        : leave HALT and clear halt_cause
//   instr_limit    : halt after this many retirements (0 = unlimited)
//   core_pc        : current PC from the core
//   imem           : instruction-memory read bus (master side)
//   instruction    : instruction word presented to the core
//   en             : one-cycle core execute enable
//   busy / halted  : FETCH/DECODE/EXEC and HALT indicators
//   halt_cause     : reason for the last halt
//   retired_cnt    : saturating count of executed instructions since reset
//   state_dbg      : current FSM state
module core_run_sequencer
  import core_run_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_req,
  input  logic                 step_req,
  input  logic                 halt_req,
  input  logic                 clr_req,
  input  logic [CNT_W-1:0]     instr_limit,
  input  logic [XLEN-1:0]      core_pc,
  core_run_sequencer_if.master imem,
  output logic [XLEN-1:0]      instruction,
  output logic                 en,
  output logic                 busy,
  output logic                 halted,
  output halt_cause_t          halt_cause,
  output logic [CNT_W-1:0]     retired_cnt,
  output state_t               state_dbg
);

  state_t      state;
  state_t      state_nxt;
  halt_cause_t cause_nxt;
  logic        step_flag;
  logic        step_nxt;
  logic        load_instr;
  logic        retire;
  logic        is_ecall;
  logic        is_ebreak;
  logic        limit_hit;
  logic [CNT_W-1:0] cnt_plus1;
  logic [CNT_W-1:0] cnt_sat;

  core_run_sequencer_sys_instr_detect u_sys_instr_detect (
    .instr_word (imem.imem_rdata[31:0]),
    .is_ecall   (is_ecall),
    .is_ebreak  (is_ebreak)
  );

  // The read is issued straight from the state so the word arrives in DECODE.
  assign imem.imem_rd_en = (state == S_FETCH);
  assign imem.imem_addr  = (state == S_FETCH) ? core_pc : '0;

  // The limit compare uses the wrapping +1; once the counter saturates at
  // all-ones the wrapped value is 0, which never equals a nonzero limit.
  assign cnt_plus1 = retired_cnt + CNT_W'(1);
  assign cnt_sat   = (retired_cnt == '1) ? retired_cnt : cnt_plus1;
  assign limit_hit = (instr_limit != '0) && (cnt_plus1 == instr_limit);

  assign state_dbg = state;

  always_comb begin
    state_nxt  = state;
    cause_nxt  = halt_cause;
    step_nxt   = step_flag;
    load_instr = 1'b0;
    retire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (halt_req) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_EXT;
        end else if (step_req) begin
          state_nxt = S_FETCH;
          step_nxt  = 1'b1;
        end else if (run_req) begin
          state_nxt = S_FETCH;
          step_nxt  = 1'b0;
        end
      end
      S_FETCH: begin
        if (halt_req) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_EXT;
        end else begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        // External halt outranks a system opcode fetched in the same cycle.
        if (halt_req) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_EXT;
        end else if (is_ebreak) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_EBREAK;
        end else if (is_ecall) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_ECALL;
        end else begin
          state_nxt  = S_EXEC;
          load_instr = 1'b1;
        end
      end
      S_EXEC: begin
        retire = 1'b1;
        if (halt_req) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_EXT;
        end else if (limit_hit) begin
          state_nxt = S_HALT;
          cause_nxt = CAUSE_LIMIT;
        end else if (step_flag) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_HALT: begin
        if (clr_req) begin
          state_nxt = S_IDLE;
          cause_nxt = CAUSE_NONE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cause_nxt = CAUSE_NONE;
      end
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register itself (en is high exactly while in EXEC).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      step_flag   <= 1'b0;
      halt_cause  <= CAUSE_NONE;
      instruction <= XLEN'(RV32_NOP);
      retired_cnt <= '0;
      en          <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state      <= state_nxt;
      step_flag  <= step_nxt;
      halt_cause <= cause_nxt;
      if (load_instr) begin
        instruction <= imem.imem_rdata;
      end
      if (retire) begin
        retired_cnt <= cnt_sat;
      end
      en     <= (state_nxt == S_EXEC);
      busy   <= (state_nxt == S_FETCH) || (state_nxt == S_DECODE) || (state_nxt == S_EXEC);
      halted <= (state_nxt == S_HALT);
    end
  end

endmodule
